// File: rtl/ama_riscv_scoreboard_if.sv
// Issue/ID/flush/writeback bundle of the long-latency scoreboard.
// The master side drives pipeline events; the slave side (scoreboard) returns hazard state.
interface ama_riscv_scoreboard_if;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_reg_we;
    logic        issue_long;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rs1_used;
    logic        rs2_used;
    logic        flush_ex;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall_id;
    logic [31:0] busy_vec;
    logic [5:0]  pending_cnt;
    logic        wb_err;
    logic [31:0] stall_cycles;

    modport master (
        output issue_valid, issue_rd, issue_reg_we, issue_long,
        output rs1_id, rs2_id, rs1_used, rs2_used, flush_ex, wb_valid, wb_rd,
        input  stall_id, busy_vec, pending_cnt, wb_err, stall_cycles
    );

    modport slave (
        input  issue_valid, issue_rd, issue_reg_we, issue_long,
        input  rs1_id, rs2_id, rs1_used, rs2_used, flush_ex, wb_valid, wb_rd,
        output stall_id, busy_vec, pending_cnt, wb_err, stall_cycles
    );
endinterface

// File: rtl/ama_riscv_scoreboard.sv
// Pending-register scoreboard for long-latency producers; stalls ID on RAW/WAW hazards.
// Optional stall counter enabled by defining AMA_RISCV_SCOREBOARD_PERF_CNT_EN.
module ama_riscv_scoreboard (
    input  logic                  clk,
    input  logic                  rst_n,
    ama_riscv_scoreboard_if.slave sb
);
    logic [31:0] r_busy;
    logic [5:0]  r_pending;
    logic        r_wb_err;
    logic [4:0]  r_last_rd;
    logic        r_last_v;

    logic        w_wb_hit;
    logic        w_haz_rs1;
    logic        w_haz_rs2;
    logic        w_haz_waw;
    logic        w_stall;
    logic        w_alloc;
    logic        w_flush_hit;
    logic        w_wb_err_set;
    logic [31:0] w_busy_nxt;

    // A same-cycle writeback is bypassed through the write-through register file.
    function automatic logic pending_hazard(input logic [31:0] busy, input logic [4:0] rs,
                                            input logic wb_v, input logic [4:0] wb_rd);
        return (rs != 5'd0) && busy[rs] && !(wb_v && (wb_rd == rs));
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
        return c;
    endfunction

    always_comb begin
        w_wb_hit    = sb.wb_valid && (sb.wb_rd != 5'd0);
        w_haz_rs1   = sb.rs1_used && pending_hazard(r_busy, sb.rs1_id, sb.wb_valid, sb.wb_rd);
        w_haz_rs2   = sb.rs2_used && pending_hazard(r_busy, sb.rs2_id, sb.wb_valid, sb.wb_rd);
        w_haz_waw   = sb.issue_valid && sb.issue_reg_we &&
                      pending_hazard(r_busy, sb.issue_rd, sb.wb_valid, sb.wb_rd);
        w_stall     = w_haz_rs1 || w_haz_rs2 || w_haz_waw;
        w_alloc     = sb.issue_valid && sb.issue_reg_we && sb.issue_long &&
                      (sb.issue_rd != 5'd0) && !w_stall;
        w_flush_hit = sb.flush_ex && r_last_v;
        w_wb_err_set = w_wb_hit && !r_busy[sb.wb_rd] &&
                       !(w_alloc && (sb.issue_rd == sb.wb_rd)) &&
                       !(w_flush_hit && (r_last_rd == sb.wb_rd));
    end

    // Clear before set so a same-cycle allocation wins over a release or flush.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_flush_hit) w_busy_nxt[r_last_rd] = 1'b0;
        if (w_wb_hit)    w_busy_nxt[sb.wb_rd]  = 1'b0;
        if (w_alloc)     w_busy_nxt[sb.issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy    <= '0;
            r_pending <= '0;
            r_wb_err  <= 1'b0;
            r_last_v  <= 1'b0;
            r_last_rd <= '0;
        end else begin
            r_busy    <= w_busy_nxt;
            r_pending <= popcount32(w_busy_nxt);
            if (w_wb_err_set) r_wb_err <= 1'b1;
            if (sb.issue_valid) begin
                r_last_v <= w_alloc;
                if (w_alloc) r_last_rd <= sb.issue_rd;
            end else if (w_flush_hit) begin
                r_last_v <= 1'b0;
            end
        end
    end

`ifdef AMA_RISCV_SCOREBOARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign sb.stall_cycles = r_stall_cycles;
`else
    assign sb.stall_cycles = '0;
`endif

    assign sb.stall_id    = w_stall;
    assign sb.busy_vec    = r_busy;
    assign sb.pending_cnt = r_pending;
    assign sb.wb_err      = r_wb_err;
endmodule

// File: doc/ama_riscv_scoreboard.md
# ama_riscv_scoreboard

Tracks in-flight destination registers written by long-latency producers (loads, CSR reads) from issue until writeback, and stalls the ID stage when a consumer needs a value that EX-stage forwarding cannot supply. It is the producer-side complement of the operand forwarding logic. Short ALU results never enter the scoreboard; they remain the forwarding path's job. Sits between ID/EX issue control and the writeback stage.

## Interface
- No parameters; the register file is fixed at 32 entries, with x0 hardwired to zero.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `issue_valid` in 1: instruction advances from ID to EX this cycle.
- `issue_rd` in 5: destination of the issuing instruction.
- `issue_reg_we` in 1: issuing instruction writes `issue_rd`.
- `issue_long` in 1: result is available only at writeback, not forwardable from EX.
- `rs1_id`, `rs2_id` in 5: source registers of the instruction currently in ID.
- `rs1_used`, `rs2_used` in 1: the instruction in ID actually reads rs1 / rs2.
- `flush_ex` in 1: the instruction that entered EX last cycle is killed.
- `wb_valid` in 1: a long-latency result is written back this cycle.
- `wb_rd` in 5: register being written back.
- `stall_id` out 1: hold ID and inject a bubble into EX.
- `busy_vec` out 32: per-register pending bits; bit 0 is always 0.
- `pending_cnt` out 6: population count of `busy_vec`, in the range 0..31.
- `wb_err` out 1: sticky flag; a writeback targeted a non-busy register.
- `stall_cycles` out 32: count of stall cycles (see Configuration).

## Operation
- Allocation:
  - Condition: `issue_valid & issue_reg_we & issue_long & (issue_rd != 0) & !stall_id`.
  - Effect: sets `busy_vec[issue_rd]` and records `last_rd` / `last_alloc_v` = 1.
  - Any other issue clears `last_alloc_v`.
- Release: `wb_valid & (wb_rd != 0)` clears `busy_vec[wb_rd]`.
  - If that bit was already 0, set `wb_err` instead; the flag stays set until reset.
- Flush: `flush_ex & last_alloc_v` clears `busy_vec[last_rd]` and clears `last_alloc_v`.
  - `flush_ex` with `last_alloc_v`=0 has no effect.
- `stall_id` is combinational and is the OR of the following hazards:
  - RAW on rs1: `rs1_used & rs1_id!=0 & busy[rs1_id] & !(wb_valid & wb_rd==rs1_id)`.
  - RAW on rs2: same form, using rs2.
  - WAW: `issue_valid & issue_reg_we & issue_rd!=0 & busy[issue_rd] & !(wb_valid & wb_rd==issue_rd)`.
  - A same-cycle writeback releases the stall; the register file is write-through.
- Issue while `stall_id`=1 is ignored: no allocation occurs and `last_alloc_v` is cleared.
- Simultaneous events on the same register:
  - Allocate and release in the same cycle: the set wins, and `wb_err` is not raised.
  - Flush and release in the same cycle: the bit ends cleared, and `wb_err` is not raised.
  - Flush and a new allocation in the same cycle: the flush clears `last_rd`, the allocation sets `issue_rd`, and `last_*` updates to the new allocation.
- `pending_cnt` is registered and reflects `busy_vec` after the same edge.

## Timing
- Reset values:
  - `busy_vec` = 0, `pending_cnt` = 0, `wb_err` = 0, `stall_cycles` = 0, `last_alloc_v` = 0.
  - `stall_id` = 0, since it derives from the reset state.
- An allocation at edge N is visible on `busy_vec` and in `stall_id` from cycle N+1.
- Release: a writeback in cycle N removes the stall in cycle N, via the bypass term; the bit reads 0 from N+1.
- `flush_ex` is valid only in the cycle immediately after the issue it kills.
- Reset asserted mid-operation discards all pending entries at the next edge. Upstream must drain or flush in-flight loads together with the reset.

## Configuration
- `AMA_RISCV_SCOREBOARD_PERF_CNT_EN`
  - Defined: `stall_cycles` increments every cycle in which `stall_id`=1 and `rst_n`=1. It saturates at 0xFFFF_FFFF.
  - Undefined: `stall_cycles` is tied to 0, and no counter flops are synthesized.
- The port list is identical in both builds.

## Test plan
- Load-use:
  - Stimulus: issue long write to x5 at cycle 0; rs1_id=5 with rs1_used in cycles 1-3; wb_rd=5 in cycle 3.
  - Response: stall_id=1 in cycles 1-2, 0 in cycle 3; busy_vec=0x20 in cycles 1-3, 0 at cycle 4; stall_cycles=2.
- x0 and short ops:
  - Stimulus: long issue to x0, then a non-long issue to x7.
  - Response: busy_vec stays 0, pending_cnt=0, and stall_id never asserts.
- Flush:
  - Stimulus: long issue to x10, then flush_ex the next cycle.
  - Response: busy_vec[10] returns to 0 one cycle later, pending_cnt 1→0, and a later wb_rd=10 raises wb_err=1.
- WAW and same-cycle set/clear:
  - Stimulus: x3 busy; issue long to x3 while wb_rd=3.
  - Response: stall_id=0, busy_vec[3] remains 1, wb_err=0.
- Multiple pending then reset:
  - Stimulus: allocate x1, x2 and x31; assert rst_n=0 for one cycle.
  - Response: pending_cnt=3 before the reset; busy_vec=0 and pending_cnt=0 after the reset edge.
- Spurious writeback:
  - Stimulus: wb_valid with wb_rd=4 while nothing is pending.
  - Response: wb_err=1 from the next cycle, and it stays 1 until reset.
